alu_nibble_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 24 ++
 rtl/nibble_alu.sv | 43 ++++
 rtl/alu_nibble_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU and the existing 4-bit ALU:
// opcode encoding, slice width and sequencer FSM states.
package alu_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    NAND = 2'b10,
    XOR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } seq_state_e;

  function automatic logic is_arith(alu_op_e op);
    return (op == ADD) || (op == SUB);
  endfunction

endpackage

// File: rtl/nibble_alu.sv
// Combinational 4-bit ALU slice. Ripple carry is exposed at both ends of the
// MSB so the caller can form signed overflow on the top slice.
module nibble_alu
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  alu_op_e             op,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] y,
  output logic                cout,
  output logic                c_msb
);

  logic [NIBBLE_W-1:0] b_eff;
  logic [NIBBLE_W-1:0] sum;
  logic [NIBBLE_W:0]   carry;

  // SUB is A + ~B + 1; the +1 arrives as cin on the first slice.
  assign b_eff    = (op == SUB) ? ~b : b;
  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_ripple
      assign sum[gi]     = a[gi] ^ b_eff[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
    end
  endgenerate

  assign cout  = carry[NIBBLE_W];
  assign c_msb = carry[NIBBLE_W-1];

  always_comb begin
    y = sum;
    case (op)
      ADD, SUB: y = sum;
      NAND:     y = ~(a & b);
      XOR:      y = a ^ b;
      default:  y = sum;
    endcase
  end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Multi-cycle W-bit ALU: iterates a 4-bit slice LSB-first, chaining carry
// through a flop, and presents result plus overflow/zero/negative flags.
module alu_nibble_sequencer
  import alu_pkg::*;
#(
  parameter  int NUM_NIBBLES = 4,
  localparam int W           = NIBBLE_W * NUM_NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_ovfl,
  output logic         rsp_zero,
  output logic         rsp_neg,
  output logic         busy
);

  localparam int IDX_W = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

  seq_state_e          state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg;
  alu_op_e             op_reg;
  logic [W-1:0]        a_reg, b_reg;
  logic [W-1:0]        result_reg;
  logic [W-1:0]        result_next;
  logic                carry_reg;
  logic                ovfl_reg;

  logic [NIBBLE_W-1:0] nib_y;
  logic                nib_cout;
  logic                nib_c_msb;
  logic                last_nibble;

  assign last_nibble = (idx_reg == LAST_IDX);

  nibble_alu u_nibble_alu (
    .a     (a_reg[NIBBLE_W-1:0]),
    .b     (b_reg[NIBBLE_W-1:0]),
    .op    (op_reg),
    .cin   (carry_reg),
    .y     (nib_y),
    .cout  (nib_cout),
    .c_msb (nib_c_msb)
  );

  // Each new slice enters at the top; after NUM_NIBBLES shifts slice 0 sits at bit 0.
  assign result_next = (result_reg >> NIBBLE_W) | (W'(nib_y) << (W - NIBBLE_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_next = EXEC;
      end
      EXEC: begin
        if (last_nibble) state_next = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg    <= '0;
      op_reg     <= ADD;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      ovfl_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            op_reg     <= alu_op_e'(req_op);
            a_reg      <= req_a;
            b_reg      <= req_b;
            result_reg <= '0;
            idx_reg    <= '0;
            carry_reg  <= (alu_op_e'(req_op) == SUB);
            ovfl_reg   <= 1'b0;
          end
        end
        EXEC: begin
          a_reg      <= a_reg >> NIBBLE_W;
          b_reg      <= b_reg >> NIBBLE_W;
          result_reg <= result_next;
          carry_reg  <= nib_cout;
          idx_reg    <= idx_reg + IDX_W'(1);
          if (last_nibble) begin
            ovfl_reg <= is_arith(op_reg) & (nib_c_msb ^ nib_cout);
          end
        end
        default: ;
      endcase
    end
  end

  // Response fields are forced to zero outside DONE so nothing partial leaks out.
  always_comb begin
    rsp_result = '0;
    rsp_ovfl   = 1'b0;
    rsp_zero   = 1'b0;
    rsp_neg    = 1'b0;
    if (state_reg == DONE) begin
      rsp_result = result_reg;
      rsp_ovfl   = ovfl_reg;
      rsp_zero   = (result_reg == '0);
      rsp_neg    = result_reg[W-1];
    end
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed self-checking bench for alu_nibble_sequencer at the default width.
module tb_alu_nibble_sequencer;

  localparam int NUM_NIBBLES = 4;
  localparam int W = 4 * NUM_NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_result;
  logic         rsp_ovfl;
  logic         rsp_zero;
  logic         rsp_neg;
  logic         busy;

  int checks = 0;
  int errors = 0;

  alu_nibble_sequencer #(.NUM_NIBBLES(NUM_NIBBLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_ovfl   (rsp_ovfl),
    .rsp_zero   (rsp_zero),
    .rsp_neg    (rsp_neg),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, busy, rsp_valid, rsp_result, rsp_ovfl, rsp_zero, rsp_neg} !== {1'b1, 1'b0, 1'b0, 16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%0b busy=%0b vld=%0b res=%h o/z/n=%0b%0b%0b, want rdy=1 busy=0 vld=0 res=0000 o/z/n=000",
               req_ready, busy, rsp_valid, rsp_result, rsp_ovfl, rsp_zero, rsp_neg);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%0b busy=%0b, want rdy=1 busy=0", req_ready, busy);
    end
    $display("reset: rdy=%0b busy=%0b vld=%0b", req_ready, busy, rsp_valid);
  endtask

  // Issue one request with rsp_ready high and check latency, result, flags and return to idle.
  task automatic test_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res,
                         input logic exp_o, input logic exp_z, input logic exp_n);
    int lat;
    rsp_ready = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_a     = ~a;
    req_b     = ~b;
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept: got busy=%0b rdy=%0b vld=%0b, want busy=1 rdy=0 vld=0", name, busy, req_ready, rsp_valid);
    end
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != NUM_NIBBLES) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, want %0d", name, lat, NUM_NIBBLES);
    end
    checks++;
    if (rsp_result !== exp_res || rsp_ovfl !== exp_o || rsp_zero !== exp_z || rsp_neg !== exp_n) begin
      errors++;
      $display("FAIL %s_result: got res=%h o/z/n=%0b%0b%0b, want res=%h o/z/n=%0b%0b%0b",
               name, rsp_result, rsp_ovfl, rsp_zero, rsp_neg, exp_res, exp_o, exp_z, exp_n);
    end
    $display("%s: a=%h b=%h res=%h ovfl=%0b zero=%0b neg=%0b lat=%0d", name, a, b, rsp_result, rsp_ovfl, rsp_zero, rsp_neg, lat);
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_handshake: got vld=%0b rdy=%0b busy=%0b, want vld=0 rdy=1 busy=0", name, rsp_valid, req_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] held;
    rsp_ready = 1'b0;
    req_op    = 2'b00;
    req_a     = 16'h0102;
    req_b     = 16'h0304;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 16'h0406) begin
      errors++;
      $display("FAIL bp_result: got vld=%0b res=%h, want vld=1 res=0406", rsp_valid, rsp_result);
    end
    held = 16'h0406;
    for (int i = 0; i < 3; i++) begin
      req_valid = (i % 2 == 0);
      req_a     = 16'hFFFF - 16'(i);
      req_op    = 2'b11;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== held || req_ready !== 1'b0 || rsp_zero !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got vld=%0b res=%h rdy=%0b zero=%0b, want vld=1 res=%h rdy=0 zero=0",
                 i, rsp_valid, rsp_result, req_ready, rsp_zero, held);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got vld=%0b rdy=%0b, want vld=0 rdy=1", rsp_valid, req_ready);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_single: got busy=%0b vld=%0b, want busy=0 vld=0", busy, rsp_valid);
    end
    $display("backpressure: held res=%h for 3 cycles, one response", held);
  endtask

  task automatic test_reset_mid_exec();
    rsp_ready = 1'b1;
    req_op    = 2'b00;
    req_a     = 16'h1111;
    req_b     = 16'h2222;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, busy, rsp_valid, rsp_result, rsp_ovfl, rsp_zero, rsp_neg} !== {1'b1, 1'b0, 1'b0, 16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%0b busy=%0b vld=%0b res=%h o/z/n=%0b%0b%0b, want rdy=1 busy=0 vld=0 res=0000 o/z/n=000",
               req_ready, busy, rsp_valid, rsp_result, rsp_ovfl, rsp_zero, rsp_neg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_noresp_%0d: got vld=%0b busy=%0b, want vld=0 busy=0", i, rsp_valid, busy);
      end
    end
    $display("reset_mid_exec: aborted, no response");
    test_op("add_after_reset", 2'b00, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_op("add_ovfl",   2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1);
    test_op("sub_zero",   2'b01, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0);
    test_op("sub_ovfl",   2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    test_op("add_ripple", 2'b00, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b0);
    test_op("add_plain",  2'b00, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0);
    test_op("sub_neg",    2'b01, 16'h0001, 16'h0003, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    test_op("nand_zero",  2'b10, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);
    test_op("nand_mix",   2'b10, 16'h00FF, 16'h0F0F, 16'hFFF0, 1'b0, 1'b0, 1'b1);
    test_op("xor",        2'b11, 16'hA5A5, 16'h0F0F, 16'hAAAA, 1'b0, 1'b0, 1'b1);
    test_op("xor_big",    2'b11, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b0);
    test_backpressure();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
